vec_magnitude_seq: RTL and testbench

//   Multi-cycle, parametrised vector-magnitude unit: floor(sqrt(x^2+y^2)) or x^2+y^2 (per-transaction mode).
//   No multipliers, no combinational loops: shift-add squaring + digit-by-digit integer square root, one step/cycle.

---
 rtl/vec_magnitude_seq_pkg.sv | 32 +++
 rtl/vec_magnitude_seq_isqrt_step.sv | 32 +++
 rtl/vec_magnitude_seq.sv | 184 ++++++++++++++++++
 tb/tb_vec_magnitude_seq.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_magnitude_seq_pkg.sv
// ============================================================================
// Module : vec_mag_pkg
// Brief  : Shared FSM state type and latency/width helpers for vec_magnitude_seq
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vec_mag_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SQ_X = 3'd1,
        SQ_Y = 3'd2,
        SQRT = 3'd3,
        DONE = 3'd4
    } state_t;

    function automatic int lat_mag(input int w);
        return 3 * w + 1;
    endfunction

    function automatic int lat_sos(input int w);
        return 2 * w;
    endfunction

    function automatic int res_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vec_magnitude_seq_isqrt_step.sv
// ============================================================================
// Module : isqrt_step
// Brief  : One restoring digit step of integer square root (two radicand bits)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module isqrt_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+2:0] rem_i,
    input  logic [WIDTH:0]   root_i,
    input  logic [1:0]       bits_i,
    output logic [WIDTH+2:0] rem_o,
    output logic [WIDTH:0]   root_o
);

    logic [WIDTH+2:0] w_rem_sh;
    logic [WIDTH+2:0] w_trial;
    logic             w_ge;

    // Remainder never exceeds 2*root, so the shifted value fits without loss.
    assign w_rem_sh = (rem_i << 2) | {{(WIDTH+1){1'b0}}, bits_i};
    assign w_trial  = {root_i, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);

    assign rem_o  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign root_o = (root_i << 1) | {{WIDTH{1'b0}}, w_ge};

endmodule

`default_nettype wire

// File: rtl/vec_magnitude_seq.sv
// ============================================================================
// Module : vec_magnitude_seq
// Brief  : Multi-cycle floor(sqrt(x^2+y^2)) / x^2+y^2 engine, valid/ready I/O
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vec_magnitude_seq
    import vec_mag_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_x,
    input  logic [WIDTH-1:0]   in_y,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH:0]   out_result,
    output logic               out_mode,
    output logic               busy
);

    localparam int RES_W = res_w(WIDTH);
    localparam int REM_W = WIDTH + 3;
    localparam int RAD_W = 2 * WIDTH + 2;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] SQ_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] RT_LAST = CNT_W'(WIDTH);

    state_t                 state_q,  state_d;
    logic [CNT_W-1:0]       cnt_q,    cnt_d;
    logic [WIDTH-1:0]       y_q,      y_d;
    logic                   mode_q,   mode_d;
    logic [RES_W-1:0]       acc_q,    acc_d;
    logic [2*WIDTH-1:0]     mcand_q,  mcand_d;
    logic [WIDTH-1:0]       mplier_q, mplier_d;
    logic [RAD_W-1:0]       rad_q,    rad_d;
    logic [REM_W-1:0]       rem_q,    rem_d;
    logic [WIDTH:0]         root_q,   root_d;
    logic [RES_W-1:0]       res_q,    res_d;
    logic                   omode_q,  omode_d;

    logic [RES_W-1:0]       w_addend;
    logic [RES_W-1:0]       w_acc_sum;
    logic [REM_W-1:0]       w_rem_nxt;
    logic [WIDTH:0]         w_root_nxt;

    isqrt_step #(
        .WIDTH (WIDTH)
    ) u_isqrt_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (rad_q[RAD_W-1 -: 2]),
        .rem_o  (w_rem_nxt),
        .root_o (w_root_nxt)
    );

    // Shift-add squaring: multiplicand walks left while multiplier walks right.
    assign w_addend  = mplier_q[0] ? {1'b0, mcand_q} : '0;
    assign w_acc_sum = acc_q + w_addend;

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = res_q;
    assign out_mode   = omode_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        rad_d    = rad_q;
        rem_d    = rem_q;
        root_d   = root_q;
        res_d    = res_q;
        omode_d  = omode_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d  = {{WIDTH{1'b0}}, in_x};
                    mplier_d = in_x;
                    y_d      = in_y;
                    mode_d   = in_mode;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = SQ_X;
                end
            end
            SQ_X: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == SQ_LAST) begin
                    mcand_d  = {{WIDTH{1'b0}}, y_q};
                    mplier_d = y_q;
                    cnt_d    = '0;
                    state_d  = SQ_Y;
                end
            end
            SQ_Y: begin
                acc_d    = w_acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == SQ_LAST) begin
                    cnt_d = '0;
                    if (mode_q) begin
                        res_d   = w_acc_sum;
                        omode_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        rad_d   = {1'b0, w_acc_sum};
                        rem_d   = '0;
                        root_d  = '0;
                        state_d = SQRT;
                    end
                end
            end
            SQRT: begin
                rem_d  = w_rem_nxt;
                root_d = w_root_nxt;
                rad_d  = rad_q << 2;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == RT_LAST) begin
                    cnt_d   = '0;
                    res_d   = {{(RES_W-WIDTH-1){1'b0}}, w_root_nxt};
                    omode_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_q      <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            rad_q    <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            res_q    <= '0;
            omode_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            rad_q    <= rad_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            res_q    <= res_d;
            omode_q  <= omode_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vec_magnitude_seq.sv
// ============================================================================
// Module : tb_vec_magnitude_seq
// Brief  : Scoreboard bench for vec_magnitude_seq (W=8 main, W=4 corner build)
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vec_magnitude_seq;

    localparam int W  = 8;
    localparam int W4 = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, in_mode, out_valid, out_ready, out_mode, busy;
    logic [W-1:0]   in_x, in_y;
    logic [2*W:0]   out_result;

    logic           in_valid4, in_ready4, in_mode4, out_valid4, out_ready4, out_mode4, busy4;
    logic [W4-1:0]  in_x4, in_y4;
    logic [2*W4:0]  out_result4;

    typedef struct packed {
        logic [2*W:0] res;
        logic         mode;
    } exp_t;

    exp_t sb_q[$];
    exp_t sb_e;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_ready = 1'b0;

    vec_magnitude_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_mode   (out_mode),
        .busy       (busy)
    );

    vec_magnitude_seq #(.WIDTH(W4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_x       (in_x4),
        .in_y       (in_y4),
        .in_mode    (in_mode4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_result (out_result4),
        .out_mode   (out_mode4),
        .busy       (busy4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int unsigned isqrt_ref(input int unsigned v);
        int unsigned r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Completion is decided at the next rising edge; sample on the falling edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 64'(out_result), 64'hFFFF_FFFF);
            end else begin
                sb_e = sb_q.pop_front();
                check("sb_result", 64'(out_result), 64'(sb_e.res));
                check("sb_mode", 64'(out_mode), 64'(sb_e.mode));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic m, input bit push);
        int          guard;
        int unsigned xx, yy, s;
        exp_t        e;
        guard = 0;
        while (!in_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_x     = x;
        in_y     = y;
        in_mode  = m;
        if (push) begin
            xx     = x;
            yy     = y;
            s      = xx * xx + yy * yy;
            e.res  = m ? (2*W+1)'(s) : (2*W+1)'(isqrt_ref(s));
            e.mode = m;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid && cyc < 200);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic m, input int lat);
        int cyc;
        send(x, y, m, 1'b1);
        wait_out(cyc);
        check(tag, 64'(cyc), 64'(lat));
        @(posedge clk); #1;
    endtask

    task automatic run4(input string tag, input logic [W4-1:0] x, input logic [W4-1:0] y,
                        input logic m, input int exp_res, input int lat);
        int cyc;
        in_valid4 = 1'b1;
        in_x4     = x;
        in_y4     = y;
        in_mode4  = m;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!out_valid4 && cyc < 100);
        check({tag, "_lat"}, 64'(cyc), 64'(lat));
        check({tag, "_res"}, 64'(out_result4), 64'(exp_res));
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        int guard;

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_x       = '0;
        in_y       = '0;
        in_mode    = 1'b0;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        in_x4      = '0;
        in_y4      = '0;
        in_mode4   = 1'b0;
        out_ready4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_result", 64'(out_result), 64'd0);
        check("rst_out_mode", 64'(out_mode), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // W=4 build corners
        run4("w4_mag_15_15", 4'd15, 4'd15, 1'b0, 21, 13);
        run4("w4_sos_15_15", 4'd15, 4'd15, 1'b1, 450, 8);

        // W=8 directed cases (results checked by the scoreboard)
        directed("lat_mag_3_4", 8'd3, 8'd4, 1'b0, 25);
        directed("lat_sos_3_4", 8'd3, 8'd4, 1'b1, 16);
        directed("lat_mag_255", 8'd255, 8'd255, 1'b0, 25);
        directed("lat_sos_255", 8'd255, 8'd255, 1'b1, 16);
        directed("lat_mag_0_0", 8'd0, 8'd0, 1'b0, 25);
        directed("lat_sos_1_0", 8'd1, 8'd0, 1'b1, 16);

        // Backpressure in DONE
        out_ready = 1'b0;
        send(8'd7, 8'd24, 1'b0, 1'b1);
        wait_out(cyc);
        check("bp_lat", 64'(cyc), 64'd25);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_x     = 8'($urandom);
            in_y     = 8'($urandom);
            in_mode  = 1'b1;
            @(posedge clk); #1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_out_result", 64'(out_result), 64'd25);
            check("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 64'(out_valid), 64'd0);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Reset during SQRT aborts the transaction
        send(8'd6, 8'd8, 1'b0, 1'b0);
        repeat (18) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(busy), 64'd1);
        check("abort_valid_before", 64'(out_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_result", 64'(out_result), 64'd0);
        directed("lat_mag_6_8", 8'd6, 8'd8, 1'b0, 25);

        // Random sweep with random valid gaps and consumer stalls
        rand_ready = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                @(posedge clk); #1;
            end
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        guard = 0;
        while (sb_q.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check("sb_drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
